// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 convolution feature-map engine:
//   - default Q-format (Q8.8 on a 16-bit word)
//   - accumulator width function
//   - leaky-ReLU shift (slope 1/8)
//   - saturation helper working on a wide signed container
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;

  // Negative accumulator values are scaled by 2^-LEAKY_SHIFT.
  localparam int LEAKY_SHIFT = 3;

  // Container width used by saturate(); must be >= the accumulator width.
  localparam int SAT_W = 64;

  // Width that holds the sum of 9*ch full-precision products without overflow.
  function automatic int acc_w(input int dw, input int ch);
    return 2 * dw + $clog2(9 * ch) + 1;
  endfunction

  // Clip a signed value to the range of a dw-bit signed word.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_window_3x3.sv
// -----------------------------------------------------------------------------
// conv_window_3x3
// One input channel's 3x3 sliding window over a raster pixel stream.
// Two line buffers hold the previous two rows; a 3x3 shift register holds
// the current window. The window is flagged valid when the accepted beat
// completes a full valid-only window that lands on the stride grid.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   valid_i        pixel beat accepted this cycle
//   row_i, col_i   position of the accepted beat (already sof-corrected)
//   pix_i          pixel value for this channel
//   win_o          window, tap (ky*3+kx) at [(ky*3+kx)*DW +: DW];
//                  ky=0 is the oldest row, kx=0 the leftmost column
//   win_valid_o    win_o holds a window that must be convolved
// -----------------------------------------------------------------------------
module conv_window_3x3 #(
  parameter int IMG_SIZE   = 416,
  parameter int DATA_WIDTH = 16,
  parameter int STRIDE     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [$clog2(IMG_SIZE)-1:0]   row_i,
  input  logic [$clog2(IMG_SIZE)-1:0]   col_i,
  input  logic [DATA_WIDTH-1:0]         pix_i,
  output logic [9*DATA_WIDTH-1:0]       win_o,
  output logic                          win_valid_o
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_SIZE);

  logic [DW-1:0] lb0_q [IMG_SIZE];  // row r-1
  logic [DW-1:0] lb1_q [IMG_SIZE];  // row r-2
  logic [DW-1:0] win_q [3][3];
  logic          win_valid_q;
  logic          win_ok;

  // NOTE: line buffers and window data have no reset; every location is
  // rewritten by a new frame before a valid window can reference it, and
  // leaving them unreset lets the buffers map onto plain RAM.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      lb0_q[col_i] <= pix_i;
      lb1_q[col_i] <= lb0_q[col_i];
      for (int ky = 0; ky < 3; ky++) begin
        win_q[ky][0] <= win_q[ky][1];
        win_q[ky][1] <= win_q[ky][2];
      end
      win_q[0][2] <= lb1_q[col_i];
      win_q[1][2] <= lb0_q[col_i];
      win_q[2][2] <= pix_i;
    end
  end

  // Output (r,c) completes at input (r+2,c+2); with stride 2 only even r,c
  // are kept, which is the same as an even input row/col.
  assign win_ok = valid_i && (row_i >= CW'(2)) && (col_i >= CW'(2)) &&
                  ((STRIDE == 1) || (!row_i[0] && !col_i[0]));

  always_ff @(posedge clk) begin
    if (rst) win_valid_q <= 1'b0;
    else     win_valid_q <= win_ok;
  end

  always_comb begin
    win_o = '0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        win_o[(ky*3+kx)*DW +: DW] = win_q[ky][kx];
      end
    end
  end

  assign win_valid_o = win_valid_q;

endmodule

// File: rtl/conv3x3_featuremap_mc.sv
// -----------------------------------------------------------------------------
// conv3x3_featuremap_mc
// Multi-channel 3x3 valid-only convolution producing one output feature map,
// with runtime-loadable weights/bias, stride 1 or 2, fused leaky-ReLU and
// saturation. Pipeline: S0 window, S1 multiply, S2 adder tree,
// S3 bias + activation + saturation (output register).
//
// Ports:
//   Clk, Rst    clock, synchronous active-high reset
//   data_in     CHANNELS pixels, channel k at [k*DW +: DW]
//   valid_in    data_in beat valid
//   sof_in      with valid_in: this beat is pixel (0,0)
//   w_we        weight/bias write strobe
//   w_addr      ch*9 + ky*3 + kx for weights, 9*CHANNELS for the bias
//   w_data      signed Q-format weight/bias value
//   data_out    output pixel, Q-format
//   valid_out   data_out valid
// -----------------------------------------------------------------------------
module conv3x3_featuremap_mc
  import conv_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int IMG_SIZE   = 416,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int STRIDE     = 1
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   data_in,
  input  logic                             valid_in,
  input  logic                             sof_in,
  input  logic                             w_we,
  input  logic [$clog2(9*CHANNELS+1)-1:0]  w_addr,
  input  logic [DATA_WIDTH-1:0]            w_data,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid_out
);

  localparam int DW    = DATA_WIDTH;
  localparam int NTAP  = 9 * CHANNELS;
  localparam int NW    = NTAP + 1;
  localparam int CW    = $clog2(IMG_SIZE);
  localparam int ACC_W = acc_w(DATA_WIDTH, CHANNELS);

  function automatic logic signed [2*DW-1:0] sx_prod(input logic [DW-1:0] v);
    return {{DW{v[DW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sx_acc(input logic [2*DW-1:0] v);
    return {{(ACC_W-2*DW){v[2*DW-1]}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Pixel counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] row_q, col_q, row_d, col_d;
  logic [CW-1:0] pos_row, pos_col;

  // NOTE: every variable driven here gets a default before any branch so the
  // block stays purely combinational (no latch on row_d/col_d when idle).
  always_comb begin
    pos_row = sof_in ? '0 : row_q;
    pos_col = sof_in ? '0 : col_q;
    row_d   = row_q;
    col_d   = col_q;
    if (valid_in) begin
      if (pos_col == CW'(IMG_SIZE - 1)) begin
        col_d = '0;
        row_d = (pos_row == CW'(IMG_SIZE - 1)) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S0: per-channel window generators
  // ---------------------------------------------------------------------------
  logic [9*DW-1:0]     win_flat [CHANNELS];
  logic [CHANNELS-1:0] win_vld;
  logic                s0_valid;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_win
    conv_window_3x3 #(
      .IMG_SIZE   (IMG_SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .STRIDE     (STRIDE)
    ) u_win (
      .clk         (Clk),
      .rst         (Rst),
      .valid_i     (valid_in),
      .row_i       (pos_row),
      .col_i       (pos_col),
      .pix_i       (data_in[ch*DW +: DW]),
      .win_o       (win_flat[ch]),
      .win_valid_o (win_vld[ch])
    );
  end

  // All channels see the same positions, so their flags are identical.
  assign s0_valid = &win_vld;

  // ---------------------------------------------------------------------------
  // Weight and bias registers (bias at index NTAP)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] w_q [NW];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else if (w_we && (32'(w_addr) < NW)) begin
      w_q[w_addr] <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: products, using the weights present in the cycle the stage executes
  // ---------------------------------------------------------------------------
  logic signed [2*DW-1:0] prod_q [NTAP];
  logic                   s1_valid_q;

  always_ff @(posedge Clk) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int k = 0; k < 9; k++) begin
        prod_q[ch*9+k] <= sx_prod(win_flat[ch][k*DW +: DW]) * sx_prod(w_q[ch*9+k]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: adder tree
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic                    s2_valid_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NTAP; i++) sum_d = sum_d + sx_acc(prod_q[i]);
  end

  always_ff @(posedge Clk) begin
    sum_q <= sum_d;
  end

  // ---------------------------------------------------------------------------
  // S3: bias, leaky-ReLU, rescale, saturate
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] bias_ext, acc, acc_act, acc_sh;
  logic signed [SAT_W-1:0] sat_full;
  logic        [DW-1:0]    data_d;
  logic                    sat_unused;

  always_comb begin
    bias_ext = {{(ACC_W-DW){w_q[NTAP][DW-1]}}, w_q[NTAP]};
    // Products carry 2*FRAC_BITS fraction bits; align the bias to match.
    acc      = sum_q + (bias_ext <<< FRAC_BITS);
    acc_act  = acc[ACC_W-1] ? (acc >>> LEAKY_SHIFT) : acc;
    acc_sh   = acc_act >>> FRAC_BITS;
    sat_full = saturate({{(SAT_W-ACC_W){acc_sh[ACC_W-1]}}, acc_sh}, DW);
    data_d   = sat_full[DW-1:0];
  end

  // Upper bits are a sign extension of data_d after saturation.
  assign sat_unused = ^sat_full[SAT_W-1:DW];

  // ---------------------------------------------------------------------------
  // Pipeline valids and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= '0;
    end else begin
      s1_valid_q <= s0_valid;
      s2_valid_q <= s1_valid_q;
      valid_out  <= s2_valid_q;
      if (s2_valid_q) data_out <= data_d;
    end
  end

endmodule
